logic_gate_unit: RTL and testbench
==================================

LOGIC_GATE_UNIT -- requirements
Module: logic_gate_unit

Interface
REQ-001 Parameter W, default 8: operand and result width in bits, legal range 1..32.
REQ-002 Parameter N, default 2: number of operands, legal range 2..8.
REQ-003 Parameter CNT_W, default 16: width of the result counter.
REQ-004 Port clk, input, 1 bit: sole clock, rising-edge active.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port in_valid, input, 1 bit: operands and op are valid this cycle.
REQ-007 Port in_ready, output, 1 bit: unit accepts an input this cycle.
REQ-008 Port op, input, 3 bits: operation select, sampled with the operands.
REQ-009 Port a_bus, input, N*W bits: packed operands; operand k occupies bits [k*W+W-1 : k*W].
REQ-010 Port out_valid, output, 1 bit: y holds a valid result.
REQ-011 Port out_ready, input, 1 bit: consumer accepts y this cycle.
REQ-012 Port y, output, W bits: registered result.
REQ-013 Port op_count, output, CNT_W bits: number of results delivered.

Function
REQ-014 Opcodes shall be: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR (all bitwise across all N operands), 110 BUF (operand 0), 111 NOT (bitwise inverse of operand 0).
REQ-015 NAND, NOR and XNOR shall be the bitwise inverse of the N-input AND, OR and XOR reduction, not a chain of 2-input inverted gates.
REQ-016 Input handshake: an input is accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-017 in_ready shall be combinational: in_ready = !out_valid || out_ready.
REQ-018 Latency: the result of an accepted input appears on y with out_valid=1 on the next cycle.
REQ-019 Output handshake: a result is delivered on a rising edge where out_valid=1 and out_ready=1.
REQ-020 While out_valid=1 and out_ready=0, y and out_valid shall hold stable and no input shall be accepted.
REQ-021 Simultaneous delivery and acceptance in one cycle: the new result replaces y, out_valid stays 1, no bubble.
REQ-022 Delivery with no new acceptance: out_valid falls to 0 next cycle and y holds its last value.
REQ-023 op_count shall increment by 1 on each delivery and saturate at all-ones; it shall never wrap.
REQ-024 Inputs presented while in_valid=0 shall have no effect on any output.
REQ-025 Sustained throughput with out_ready held at 1 shall be one result per cycle.

Reset
REQ-026 While rst_n=0: out_valid=0, y=0, op_count=0, and y_par=0 when present; this shall apply immediately, independent of clk.
REQ-027 A result pending at reset shall be discarded, not delivered and not counted.
REQ-028 The first acceptance after reset is possible on the first rising edge with rst_n=1.

Configuration
REQ-029 Macro LGU_PARITY_EN defined: add port y_par, output, 1 bit, giving the even parity (XOR of all bits) of y, registered with y and following the same hold rules.
REQ-030 Macro LGU_PARITY_EN undefined: y_par and its logic shall be absent; all other behaviour is unchanged.

Structure
REQ-031 Package lgu_pkg shall hold the op encoding constants (OP_AND .. OP_NOT) and the opcode width constant (3).
REQ-032 Sub-module lgu_reduce shall be purely combinational: it takes a_bus and op and returns the W-bit result. logic_gate_unit shall hold the handshake registers and the counter.

Verification
REQ-033 W=8, N=2: apply 00/00, 00/FF, FF/00, FF/FF with op=OR -> y = 00, FF, FF, FF, each one cycle after acceptance, op_count=4.
REQ-034 W=4, N=3: operands 1,2,4 -> op XOR gives 7, op XNOR gives 8, op NAND gives F, op NOT gives E.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, y is stable, op_count is unchanged; on release, one delivery and then the next input is accepted.
REQ-036 CNT_W=2, out_ready=1: stream 6 inputs -> op_count reads 1, 2, 3, 3, 3, 3.
REQ-037 Assert rst_n=0 mid-cycle while out_valid=1 -> out_valid=0, y=0, op_count=0 without waiting for a clock edge, and the pending result is never delivered.
REQ-038 With LGU_PARITY_EN defined: y=8'hA7 -> y_par=1, and y=8'h03 -> y_par=0.

Source files
------------

// File: rtl/lgu_pkg.sv
// Shared opcode encoding for the logic gate unit and its reduction datapath.
package lgu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_BUF  = 3'b110,
        OP_NOT  = 3'b111
    } op_e;

endpackage

// File: rtl/lgu_reduce.sv
// Combinational N-operand bitwise reduction selected by op; no state.
module lgu_reduce
    import lgu_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 2
) (
    input  logic [N*W-1:0]  a_bus,
    input  logic [OP_W-1:0] op,
    output logic [W-1:0]    result
);

    logic [W-1:0] and_r;
    logic [W-1:0] or_r;
    logic [W-1:0] xor_r;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        and_r = '1;
        or_r  = '0;
        xor_r = '0;
        for (int k = 0; k < N; k++) begin
            and_r &= a_bus[k*W +: W];
            or_r  |= a_bus[k*W +: W];
            xor_r ^= a_bus[k*W +: W];
        end
    end

    // Inverted ops invert the full N-input reduction, not a chain of 2-input gates.
    always_comb begin
        result = '0;
        case (op_e'(op))
            OP_AND:  result = and_r;
            OP_OR:   result = or_r;
            OP_XOR:  result = xor_r;
            OP_NAND: result = ~and_r;
            OP_NOR:  result = ~or_r;
            OP_XNOR: result = ~xor_r;
            OP_BUF:  result = a_bus[W-1:0];
            OP_NOT:  result = ~a_bus[W-1:0];
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/logic_gate_unit.sv
// One-deep registered logic unit with valid/ready handshake and saturating delivery counter.
// Optional macro LGU_PARITY_EN adds y_par, the registered XOR of all bits of y.
module logic_gate_unit
    import lgu_pkg::*;
#(
    parameter int W     = 8,
    parameter int N     = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [N*W-1:0]   a_bus,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     y,
    output logic [CNT_W-1:0] op_count
`ifdef LGU_PARITY_EN
    ,
    output logic             y_par
`endif
);

    logic         accept;
    logic         deliver;
    logic [W-1:0] result;

    // The output register can take a new result in the same cycle its old one leaves.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign deliver  = out_valid && out_ready;

    lgu_reduce #(
        .W (W),
        .N (N)
    ) u_reduce (
        .a_bus  (a_bus),
        .op     (op),
        .result (result)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            y         <= result;
        end else if (deliver) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (deliver && (op_count != '1)) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

`ifdef LGU_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_par <= 1'b0;
        end else if (accept) begin
            y_par <= ^result;
        end
    end
`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
// Scoreboard bench for logic_gate_unit: two instances (W8/N2/CNT16 and W4/N3/CNT2).
module tb_logic_gate_unit;
    import lgu_pkg::*;

    logic clk;
    logic rst_n;

    logic        in_valid8, out_ready8, in_ready8, out_valid8;
    logic [2:0]  op8;
    logic [15:0] a8;
    logic [7:0]  y8;
    logic [15:0] cnt8;

    logic        in_valid4, out_ready4, in_ready4, out_valid4;
    logic [2:0]  op4;
    logic [11:0] a4;
    logic [3:0]  y4;
    logic [1:0]  cnt4;

`ifdef LGU_PARITY_EN
    logic y_par8, y_par4;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] q8[$];
    logic [31:0] q4[$];
    logic [31:0] m_last_y[2];
    logic [31:0] m_cnt[2];

    logic_gate_unit #(.W(8), .N(2), .CNT_W(16)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .a_bus(a8), .out_valid(out_valid8), .out_ready(out_ready8),
        .y(y8), .op_count(cnt8)
`ifdef LGU_PARITY_EN
        , .y_par(y_par8)
`endif
    );

    logic_gate_unit #(.W(4), .N(3), .CNT_W(2)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .op(op4), .a_bus(a4), .out_valid(out_valid4), .out_ready(out_ready4),
        .y(y4), .op_count(cnt4)
`ifdef LGU_PARITY_EN
        , .y_par(y_par4)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-bit count of ones across operands gives every op directly.
    function automatic logic [31:0] ref_op(input int w, input int n, input logic [2:0] op,
                                           input logic [255:0] a);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < w; b++) begin
            int ones;
            ones = 0;
            for (int k = 0; k < n; k++) ones += int'(a[k*w+b]);
            case (op)
                3'd0: r[b] = (ones == n);
                3'd1: r[b] = (ones != 0);
                3'd2: r[b] = ones[0];
                3'd3: r[b] = (ones != n);
                3'd4: r[b] = (ones == 0);
                3'd5: r[b] = !ones[0];
                3'd6: r[b] = a[b];
                default: r[b] = !a[b];
            endcase
        end
        return r;
    endfunction

    task automatic mon(input int k, input int w, input int n, input int cw,
                       input logic iv, input logic [2:0] op, input logic [255:0] a,
                       input logic ordy, input logic irdy, input logic ov,
                       input logic [31:0] y, input logic [31:0] cnt);
        string p;
        int qs;
        logic [31:0] front, r, cmax;
        p = (k == 0) ? "u8" : "u4";
        cmax = (32'd1 << cw) - 32'd1;
        if (!rst_n) begin
            check($sformatf("%s reset out_valid", p), 32'(ov), 32'd0);
            check($sformatf("%s reset y", p), y, 32'd0);
            check($sformatf("%s reset op_count", p), cnt, 32'd0);
            if (k == 0) q8.delete(); else q4.delete();
            m_last_y[k] = '0;
            m_cnt[k] = '0;
            return;
        end
        qs = (k == 0) ? q8.size() : q4.size();
        check($sformatf("%s out_valid", p), 32'(ov), 32'(qs != 0));
        check($sformatf("%s in_ready", p), 32'(irdy), 32'((qs == 0) || ordy));
        check($sformatf("%s y", p), y, m_last_y[k]);
        check($sformatf("%s op_count", p), cnt, m_cnt[k]);
        if ((qs != 0) && ordy) begin
            front = (k == 0) ? q8.pop_front() : q4.pop_front();
            check($sformatf("%s delivered y", p), y, front);
            if (m_cnt[k] != cmax) m_cnt[k] = m_cnt[k] + 32'd1;
        end
        if (iv && ((qs == 0) || ordy)) begin
            r = ref_op(w, n, op, a);
            if (k == 0) q8.push_back(r); else q4.push_back(r);
            m_last_y[k] = r;
        end
    endtask

    always @(negedge clk) begin
        mon(0, 8, 2, 16, in_valid8, op8, 256'(a8), out_ready8, in_ready8, out_valid8,
            32'(y8), 32'(cnt8));
        mon(1, 4, 3, 2, in_valid4, op4, 256'(a4), out_ready4, in_ready4, out_valid4,
            32'(y4), 32'(cnt4));
`ifdef LGU_PARITY_EN
        check("u8 y_par", 32'(y_par8), 32'(^m_last_y[0]));
        check("u4 y_par", 32'(y_par4), 32'(^m_last_y[1]));
`endif
    end

    task automatic drive8(input logic v, input logic [2:0] o, input logic [15:0] a);
        in_valid8 = v;
        op8 = o;
        a8 = a;
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic v, input logic [2:0] o, input logic [11:0] a);
        in_valid4 = v;
        op4 = o;
        a4 = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] vec033 [4];
        logic [7:0]  exp033 [4];
        logic [2:0]  ops034 [4];
        logic [3:0]  exp034 [4];
        logic [1:0]  exp036 [6];
        logic [7:0]  y_hold;
        logic [15:0] c_hold;
        logic [15:0] rd;

        vec033 = '{16'h0000, 16'hFF00, 16'h00FF, 16'hFFFF};
        exp033 = '{8'h00, 8'hFF, 8'hFF, 8'hFF};
        ops034 = '{OP_XOR, OP_XNOR, OP_NAND, OP_NOT};
        exp034 = '{4'h7, 4'h8, 4'hF, 4'hE};
        exp036 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

        rst_n = 1'b0;
        in_valid8 = 1'b0; op8 = '0; a8 = '0; out_ready8 = 1'b0;
        in_valid4 = 1'b0; op4 = '0; a4 = '0; out_ready4 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // OR over all-zero / mixed / all-one operand pairs, one cycle latency each.
        out_ready8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive8(1'b1, OP_OR, vec033[i]);
            check($sformatf("or vector %0d y", i), 32'(y8), 32'(exp033[i]));
        end
        drive8(1'b0, OP_OR, 16'h0);
        check("or stream op_count", 32'(cnt8), 32'd4);

        // Three-operand W=4 cases with operands 1, 2, 4.
        out_ready4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive4(1'b1, ops034[i], 12'h421);
            check($sformatf("w4 op %0d y", ops034[i]), 32'(y4), 32'(exp034[i]));
        end
        drive4(1'b0, OP_AND, 12'h0);

        // Backpressure: five stalled cycles, then simultaneous delivery and acceptance.
        out_ready8 = 1'b0;
        drive8(1'b1, OP_XOR, 16'($urandom));
        y_hold = y8;
        c_hold = cnt8;
        rd = 16'($urandom);
        op8 = OP_NAND;
        a8 = rd;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall in_ready", 32'(in_ready8), 32'd0);
            check("stall y", 32'(y8), 32'(y_hold));
            check("stall op_count", 32'(cnt8), 32'(c_hold));
        end
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        check("release op_count", 32'(cnt8), 32'(c_hold) + 32'd1);
        check("release new y", 32'(y8), ref_op(8, 2, OP_NAND, 256'(rd)));
        check("release out_valid", 32'(out_valid8), 32'd1);
        drive8(1'b0, OP_AND, 16'h0);

`ifdef LGU_PARITY_EN
        drive8(1'b1, OP_BUF, 16'h00A7);
        check("parity of A7", 32'(y_par8), 32'd1);
        drive8(1'b1, OP_BUF, 16'h0003);
        check("parity of 03", 32'(y_par8), 32'd0);
        drive8(1'b0, OP_AND, 16'h0);
`endif

        // Random traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            in_valid8 = 1'($urandom_range(0, 1));
            out_ready8 = 1'($urandom_range(0, 3) != 0);
            op8 = 3'($urandom_range(0, 7));
            a8 = 16'($urandom);
            in_valid4 = 1'($urandom_range(0, 1));
            out_ready4 = 1'($urandom_range(0, 3) != 0);
            op4 = 3'($urandom_range(0, 7));
            a4 = 12'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid8 = 1'b0; in_valid4 = 1'b0;
        out_ready8 = 1'b1; out_ready4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-cycle with a pending result.
        out_ready8 = 1'b0;
        drive8(1'b1, OP_AND, 16'($urandom) | 16'h0101);
        in_valid8 = 1'b0;
        check("pre-reset out_valid", 32'(out_valid8), 32'd1);
        check("pre-reset op_count nonzero", 32'(cnt8 != 16'd0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset out_valid", 32'(out_valid8), 32'd0);
        check("async reset y", 32'(y8), 32'd0);
        check("async reset op_count", 32'(cnt8), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready8 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("discarded result not counted", 32'(cnt8), 32'd0);
        check("discarded result not valid", 32'(out_valid8), 32'd0);

        // Saturating 2-bit counter over a 6-result stream.
        out_ready4 = 1'b1;
        in_valid4 = 1'b1;
        op4 = 3'($urandom_range(0, 7));
        a4 = 12'($urandom);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (i >= 1) check($sformatf("sat count %0d", i), 32'(cnt4), 32'(exp036[i-1]));
            if (i == 5) begin
                in_valid4 = 1'b0;
            end else begin
                op4 = 3'($urandom_range(0, 7));
                a4 = 12'($urandom);
            end
        end
        @(posedge clk);
        #1;
        check("sat count 6", 32'(cnt4), 32'(exp036[5]));
        repeat (2) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
